multicycle_control: RTL and testbench
=====================================

# multicycle_control

Finite-state controller that sequences the shared single-ALU / single-memory datapath of the multicycle MIPS core. It decodes the 6-bit opcode latched in the instruction register and steps through fetch, decode, execute, memory and write-back phases, driving every datapath mux select and write enable. It supports LW, SW, BEQ, R-type and J, waits on a memory-ready handshake, and keeps a retired-instruction counter.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- opcode  input  6  IR[31:26], valid from DECODE onward
- mem_ready  input  1  memory completes the current access this cycle
- PCWrite, PCWriteCond  output  1 each  unconditional / BEQ-conditional PC write
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead, MemWrite  output  1 each  memory strobes
- IRWrite  output  1  load instruction register
- MemtoReg, RegDst, RegWrite  output  1 each  write-back controls
- ALUSrcA  output  1  0 = PC, 1 = rs
- ALUSrcB  output  2  0 = rt, 1 = constant 4, 2 = sign-ext imm, 3 = sign-ext imm << 2
- ALUOp  output  2  0 = add, 1 = subtract, 2 = funct-decoded
- PCSource  output  2  0 = ALU result, 1 = ALUOut, 2 = jump target
- state  output  4  current state encoding (debug)
- instr_done  output  1  one-cycle pulse on instruction retirement
- illegal_op  output  1  one-cycle pulse on unsupported opcode
- retired  output  CNT_W  retired-instruction count

## Operation
- States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, RWB 7, BEQ 8, JUMP 9; codes 10–15 unreachable, treated as FETCH next.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSource=0; IRWrite=1 and PCWrite=1 only in the cycle mem_ready=1; advance to DECODE on mem_ready=1, otherwise hold.
- DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=0 (branch target). Next: 100011/101011 → MEMADR; 000000 → EXEC; 000100 → BEQ; 000010 → JUMP; any other → FETCH with illegal_op=1, no write enables asserted, counter unchanged.
- MEMADR: ALUSrcA=1, ALUSrcB=2, ALUOp=0; LW → MEMRD, SW → MEMWR.
- MEMRD: MemRead=1, IorD=1; hold until mem_ready, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; retire; → FETCH.
- MEMWR: MemWrite=1, IorD=1; hold until mem_ready, retire in that cycle; → FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=0, ALUOp=2; → RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0; retire; → FETCH.
- BEQ: ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCWriteCond=1, PCSource=1; retire; → FETCH.
- JUMP: PCWrite=1, PCSource=2; retire; → FETCH.
- All outputs not listed for a state are 0. Outputs are Moore decodes of state, except FETCH IRWrite/PCWrite and instr_done in MEMWR, which also depend on mem_ready.
- retired increments by 1 on each instr_done; wraps from all-ones to 0 silently.

## Timing
- Reset: at the edge with reset=1, state ← FETCH, retired ← 0. While reset=1 every control output, instr_done and illegal_op are forced 0; state reads 0.
- First FETCH outputs appear the cycle after reset deasserts.
- Cycles per instruction with mem_ready tied 1: LW 5, SW 4, R-type 4, BEQ 3, J 3; illegal 2. Each cycle mem_ready=0 in FETCH/MEMRD/MEMWR adds one cycle.
- While waiting, MemRead/MemWrite and IorD stay stable; no write enable other than the strobe is asserted.
- instr_done pulses in the final cycle of the instruction; retired shows the new value the following cycle.
- Reset asserted mid-instruction (e.g. in MEMWR with mem_ready=0): the current cycle's outputs are forced 0 immediately, the instruction is abandoned and not counted.
- opcode is sampled only in DECODE and MEMADR; changes elsewhere have no effect.

## Test plan
- Reset then mem_ready=1, opcode=100011 → states 0,1,2,3,4,0; RegWrite=1 & MemtoReg=1 only in state 4; retired=1.
- opcode=000000, mem_ready=1 → states 0,1,6,7; ALUOp=2 in 6; RegDst=RegWrite=1 in 7; instr_done one pulse.
- opcode=101011, mem_ready low 3 cycles in MEMWR → MemWrite=1 for 4 consecutive cycles, IorD=1, instr_done only in the 4th; SW takes 7 cycles.
- BEQ then J back-to-back → 3 cycles each; PCWriteCond=1 & PCSource=1 in state 8; PCWrite=1 & PCSource=2 in state 9; retired +2.
- opcode=111111 → illegal_op pulse in DECODE, return to FETCH, retired unchanged, no write enable asserted.
- Reset asserted in MEMRD with mem_ready=0 → outputs 0 that cycle, state=0 next, retired=0; preload retired to 0xFFFFFFFF via 2^32-consistent forcing, retire one R-type → retired=0.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and its datapath.
// master = controller, slave = datapath.
interface multicycle_control_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             PCWrite;
  logic             PCWriteCond;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             MemtoReg;
  logic             RegDst;
  logic             RegWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic [1:0]       PCSource;
  logic [3:0]       state;
  logic             instr_done;
  logic             illegal_op;
  logic [CNT_W-1:0] retired;

  modport master (
    input  opcode, mem_ready,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
    output IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
    output ALUSrcB, ALUOp, PCSource, state,
    output instr_done, illegal_op, retired
  );

  modport slave (
    output opcode, mem_ready,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite,
    input  IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA,
    input  ALUSrcB, ALUOp, PCSource, state,
    input  instr_done, illegal_op, retired
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS controller: FSM sequencing fetch/decode/exec/mem/wb.
// Supports LW, SW, BEQ, R-type and J; counts retired instructions.
module multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.master bus
);
  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_RWB    = 4'd7;
  localparam logic [3:0] S_BEQ    = 4'd8;
  localparam logic [3:0] S_JUMP   = 4'd9;

  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_R  = 6'b000000;
  localparam logic [5:0] OP_BQ = 6'b000100;
  localparam logic [5:0] OP_J  = 6'b000010;

  logic [3:0]       r_state;
  logic [CNT_W-1:0] r_retired;
  logic [3:0]       w_next;
  logic             w_done;
  logic             w_ill;
  logic             w_mem;
  logic             w_rtype;
  logic             w_beq;
  logic             w_jmp;

  assign w_mem   = (bus.opcode == OP_LW) ||
                   (bus.opcode == OP_SW);
  assign w_rtype = (bus.opcode == OP_R);
  assign w_beq   = (bus.opcode == OP_BQ);
  assign w_jmp   = (bus.opcode == OP_J);

  always_comb begin
    w_next = S_FETCH;
    w_done = 1'b0;
    w_ill  = 1'b0;
    case (r_state)
      S_FETCH:
        w_next = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        unique case (1'b1)
          w_mem:   w_next = S_MEMADR;
          w_rtype: w_next = S_EXEC;
          w_beq:   w_next = S_BEQ;
          w_jmp:   w_next = S_JUMP;
          default: w_ill  = 1'b1;
        endcase
      end
      S_MEMADR:
        w_next = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:
        w_next = bus.mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWB: w_done = 1'b1;
      S_MEMWR: begin
        w_next = bus.mem_ready ? S_FETCH : S_MEMWR;
        w_done = bus.mem_ready;
      end
      S_EXEC:  w_next = S_RWB;
      S_RWB:   w_done = 1'b1;
      S_BEQ:   w_done = 1'b1;
      S_JUMP:  w_done = 1'b1;
      default: w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_done)
        r_retired <= r_retired + 1'b1;
    end
  end

  // Moore decode; reset masks everything in the same cycle.
  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemtoReg    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'd0;
    bus.ALUOp       = 2'd0;
    bus.PCSource    = 2'd0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          bus.MemRead = 1'b1;
          bus.ALUSrcB = 2'd1;
          bus.IRWrite = bus.mem_ready;
          bus.PCWrite = bus.mem_ready;
        end
        S_DECODE: bus.ALUSrcB = 2'd3;
        S_MEMADR: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUSrcB = 2'd2;
        end
        S_MEMRD: begin
          bus.MemRead = 1'b1;
          bus.IorD    = 1'b1;
        end
        S_MEMWB: begin
          bus.RegWrite = 1'b1;
          bus.MemtoReg = 1'b1;
        end
        S_MEMWR: begin
          bus.MemWrite = 1'b1;
          bus.IorD     = 1'b1;
        end
        S_EXEC: begin
          bus.ALUSrcA = 1'b1;
          bus.ALUOp   = 2'd2;
        end
        S_RWB: begin
          bus.RegWrite = 1'b1;
          bus.RegDst   = 1'b1;
        end
        S_BEQ: begin
          bus.ALUSrcA     = 1'b1;
          bus.ALUOp       = 2'd1;
          bus.PCWriteCond = 1'b1;
          bus.PCSource    = 2'd1;
        end
        S_JUMP: begin
          bus.PCWrite  = 1'b1;
          bus.PCSource = 2'd2;
        end
        default: ;
      endcase
    end
  end

  assign bus.state      = reset ? 4'd0 : r_state;
  assign bus.instr_done = !reset && w_done;
  assign bus.illegal_op = !reset && w_ill;
  assign bus.retired    = r_retired;
endmodule

// File: tb/tb_multicycle_control.sv
// Random instruction stream against an instruction-level model.
// A narrow-counter twin exercises counter wrap.
module tb_multicycle_control;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;
  int   cnt = 0;

  always #5 clk = ~clk;

  multicycle_control_if #(.CNT_W(32)) bus ();
  multicycle_control_if #(.CNT_W(2))  bus2 ();

  assign bus2.opcode    = bus.opcode;
  assign bus2.mem_ready = bus.mem_ready;

  multicycle_control #(.CNT_W(32)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  multicycle_control #(.CNT_W(2)) u_dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.master)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Control word expected for a state, built from the
  // per-phase output list.
  function automatic logic [15:0] ctl_of(int st, bit mr);
    bit pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, sa;
    bit [1:0] sb, aop, psrc;
    {pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw, sa} = '0;
    sb = 0; aop = 0; psrc = 0;
    if (st == 0) begin mrd = 1; sb = 1; irw = mr; pcw = mr; end
    if (st == 1) sb = 3;
    if (st == 2) begin sa = 1; sb = 2; end
    if (st == 3) begin mrd = 1; iord = 1; end
    if (st == 4) begin rw = 1; m2r = 1; end
    if (st == 5) begin mwr = 1; iord = 1; end
    if (st == 6) begin sa = 1; aop = 2; end
    if (st == 7) begin rw = 1; rdst = 1; end
    if (st == 8) begin sa = 1; aop = 1; pcc = 1; psrc = 1; end
    if (st == 9) begin pcw = 1; psrc = 2; end
    return {pcw, pcc, iord, mrd, mwr, irw, m2r, rdst, rw,
            sa, sb, aop, psrc};
  endfunction

  function automatic logic [15:0] ctl_dut();
    return {bus.PCWrite, bus.PCWriteCond, bus.IorD,
            bus.MemRead, bus.MemWrite, bus.IRWrite,
            bus.MemtoReg, bus.RegDst, bus.RegWrite,
            bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp,
            bus.PCSource};
  endfunction

  // One clock: inputs applied, outputs compared, edge taken.
  task automatic cyc(input int st, input bit mr,
                     input logic [5:0] op, input bit done,
                     input bit ill);
    bus.mem_ready = mr;
    bus.opcode    = op;
    #2;
    check("state", 32'(bus.state), 32'(st));
    check("ctl", 32'(ctl_dut()), 32'(ctl_of(st, mr)));
    check("done", 32'(bus.instr_done), 32'(done));
    check("illegal", 32'(bus.illegal_op), 32'(ill));
    check("retired", bus.retired, 32'(cnt));
    check("retired_w2", 32'(bus2.retired), 32'(cnt % 4));
    @(posedge clk); #1;
    if (done) cnt++;
  endtask

  function automatic bit legal(logic [5:0] op);
    return op == 6'b100011 || op == 6'b101011 ||
           op == 6'b000000 || op == 6'b000100 ||
           op == 6'b000010;
  endfunction

  function automatic logic [5:0] junk();
    return 6'($urandom);
  endfunction

  // Waits of 0..2 cycles, weighted toward no wait.
  function automatic int waits();
    int r;
    r = int'($urandom_range(0, 5));
    return (r < 3) ? 0 : r - 3;
  endfunction

  task automatic fetch(input int w);
    for (int i = 0; i < w; i++) cyc(0, 0, junk(), 0, 0);
    cyc(0, 1, junk(), 0, 0);
  endtask

  // kind: 0 LW, 1 SW, 2 R, 3 BEQ, 4 J, 5 illegal
  task automatic instr(input int kind, input int fw,
                       input int mw);
    logic [5:0] op;
    bit r;
    case (kind)
      0: op = 6'b100011;
      1: op = 6'b101011;
      2: op = 6'b000000;
      3: op = 6'b000100;
      4: op = 6'b000010;
      default: begin
        op = junk();
        while (legal(op)) op = junk();
      end
    endcase
    fetch(fw);
    r = 1'($urandom);
    cyc(1, r, op, 0, kind == 5);
    case (kind)
      0: begin
        cyc(2, 1'($urandom), op, 0, 0);
        for (int i = 0; i < mw; i++) cyc(3, 0, junk(), 0, 0);
        cyc(3, 1, junk(), 0, 0);
        cyc(4, 1'($urandom), junk(), 1, 0);
      end
      1: begin
        cyc(2, 1'($urandom), op, 0, 0);
        for (int i = 0; i < mw; i++) cyc(5, 0, junk(), 0, 0);
        cyc(5, 1, junk(), 1, 0);
      end
      2: begin
        cyc(6, 1'($urandom), junk(), 0, 0);
        cyc(7, 1'($urandom), junk(), 1, 0);
      end
      3: cyc(8, 1'($urandom), junk(), 1, 0);
      4: cyc(9, 1'($urandom), junk(), 1, 0);
      default: ;
    endcase
  endtask

  task automatic reset_cycle(input bit mr);
    reset = 1'b1;
    bus.mem_ready = mr;
    bus.opcode = junk();
    #2;
    check("rst_state", 32'(bus.state), 32'd0);
    check("rst_ctl", 32'(ctl_dut()), 32'd0);
    check("rst_done", 32'(bus.instr_done), 32'd0);
    check("rst_ill", 32'(bus.illegal_op), 32'd0);
    @(posedge clk); #1;
    cnt = 0;
  endtask

  initial begin
    bus.mem_ready = 1'b0;
    bus.opcode = 6'd0;
    @(posedge clk); #1;
    reset_cycle(1);
    reset_cycle(0);
    check("rst_retired", bus.retired, 32'd0);
    reset = 1'b0;

    instr(0, 0, 0);
    check("lw_retired", bus.retired, 32'd1);
    instr(2, 0, 0);
    instr(1, 0, 3);
    instr(3, 0, 0);
    instr(4, 0, 0);
    instr(5, 0, 0);
    check("dir_retired", bus.retired, 32'd5);

    for (int n = 0; n < 80; n++)
      instr(int'($urandom_range(0, 5)), waits(), waits());

    // Abandon a load stalled in MEMRD.
    fetch(0);
    cyc(1, 1, 6'b100011, 0, 0);
    cyc(2, 1, 6'b100011, 0, 0);
    cyc(3, 0, junk(), 0, 0);
    reset_cycle(0);
    reset = 1'b0;
    check("abort_retired", bus.retired, 32'd0);
    instr(2, 1, 0);
    instr(0, 0, 2);
    check("post_retired", bus.retired, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
